sub_serial: RTL and testbench



---
 rtl/sub_serial.sv | 135 +++++++++++++
 tb/tb_sub_serial.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_serial.sv
// -----------------------------------------------------------------------------
// sub_serial
//
// Bit-serial N-bit subtractor: diff = a - b, processed one bit per clock,
// LSB first, through a single full-subtractor stage and a borrow flop.
// Operands are accepted with a start/in_ready handshake and completion is
// flagged by a one-cycle done pulse. One operation takes WIDTH+2 cycles
// from accept to the next possible accept.
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   start     : request, sampled only while in_ready = 1
//   a, b      : minuend / subtrahend, captured on the accepting edge
//   in_ready  : high while idle
//   diff      : a - b mod 2^WIDTH, held until the next completion
//   borrow    : unsigned borrow-out (a < b), held with diff
//   ovf       : two's-complement overflow, held with diff
//   done      : one-cycle pulse on the cycle results become valid
// -----------------------------------------------------------------------------
module sub_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             in_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             done
);

  // Counter only needs to reach WIDTH-1; sized with one bit of headroom.
  localparam int CW = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             bf;
  logic [CW-1:0]    cnt;
  logic             a_msb;
  logic             b_msb;

  // Full-subtractor stage on the current LSBs.
  logic             d;
  logic             bf_next;
  logic [WIDTH-1:0] sr_next;

  // NOTE: every always_comb output gets an unconditional assignment first,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    d       = sa[0] ^ sb[0] ^ bf;
    bf_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bf);
    // Shift without slicing so WIDTH = 1 elaborates cleanly.
    sr_next            = sr >> 1;
    sr_next[WIDTH-1]   = d;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sa       <= '0;
      sb       <= '0;
      sr       <= '0;
      bf       <= 1'b0;
      cnt      <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      in_ready <= 1'b1;
      done     <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa       <= a;
            sb       <= b;
            bf       <= 1'b0;
            cnt      <= '0;
            // Operand signs are kept for the overflow decision at the end,
            // since sa/sb are shifted away by then.
            a_msb    <= a[WIDTH-1];
            b_msb    <= b[WIDTH-1];
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end

        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          bf  <= bf_next;
          sr  <= sr_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            // d is the result MSB on this edge.
            diff   <= sr_next;
            borrow <= bf_next;
            ovf    <= (a_msb ^ b_msb) & (d ^ a_msb);
            done   <= 1'b1;
            state  <= DONE;
          end
        end

        DONE: begin
          done     <= 1'b0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end

        default: begin
          done     <= 1'b0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_serial.sv
// -----------------------------------------------------------------------------
// tb_sub_serial
//
// Self-checking bench for sub_serial at WIDTH = 8, 3 and 1. Expected results
// come from integer arithmetic on the operands (modular difference, unsigned
// compare, signed range test), independent of the bit-serial structure.
// -----------------------------------------------------------------------------
module tb_sub_serial;

  logic clk;
  logic rst_n;

  logic       st8, st3, st1;
  logic [7:0] a8, b8;
  logic [2:0] a3, b3;
  logic [0:0] a1, b1;

  logic       rdy8, rdy3, rdy1;
  logic       done8, done3, done1;
  logic [7:0] diff8;
  logic [2:0] diff3;
  logic [0:0] diff1;
  logic       bor8, bor3, bor1;
  logic       ovf8, ovf3, ovf1;

  int n_checks = 0;
  int n_fail   = 0;

  sub_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8),
    .in_ready(rdy8), .diff(diff8), .borrow(bor8), .ovf(ovf8), .done(done8)
  );

  sub_serial #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(st3), .a(a3), .b(b3),
    .in_ready(rdy3), .diff(diff3), .borrow(bor3), .ovf(ovf3), .done(done3)
  );

  sub_serial #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1),
    .in_ready(rdy1), .diff(diff1), .borrow(bor1), .ovf(ovf1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- helpers
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_rdy(input int w);
    case (w)
      1:       return rdy1;
      3:       return rdy3;
      default: return rdy8;
    endcase
  endfunction

  function automatic logic get_done(input int w);
    case (w)
      1:       return done1;
      3:       return done3;
      default: return done8;
    endcase
  endfunction

  function automatic logic [31:0] get_diff(input int w);
    case (w)
      1:       return 32'(diff1);
      3:       return 32'(diff3);
      default: return 32'(diff8);
    endcase
  endfunction

  function automatic logic get_bor(input int w);
    case (w)
      1:       return bor1;
      3:       return bor3;
      default: return bor8;
    endcase
  endfunction

  function automatic logic get_ovf(input int w);
    case (w)
      1:       return ovf1;
      3:       return ovf3;
      default: return ovf8;
    endcase
  endfunction

  task automatic drive(input int w, input logic s, input int av, input int bv);
    case (w)
      1: begin st1 = s; a1 = av[0:0]; b1 = bv[0:0]; end
      3: begin st3 = s; a3 = av[2:0]; b3 = bv[2:0]; end
      default: begin st8 = s; a8 = av[7:0]; b8 = bv[7:0]; end
    endcase
  endtask

  // Reference: plain integer arithmetic on w-bit operands.
  task automatic model(input int w, input int av, input int bv,
                       output int d, output int bo, output int ov);
    int m, sa, sb, r;
    m  = 1 << w;
    d  = (av - bv + m) % m;
    bo = (av < bv) ? 1 : 0;
    sa = (av >= m / 2) ? av - m : av;
    sb = (bv >= m / 2) ? bv - m : bv;
    r  = sa - sb;
    ov = (r < -(m / 2) || r > (m / 2 - 1)) ? 1 : 0;
  endtask

  // One full operation, called at a negedge; checks latency, results,
  // done width, in_ready low time and output hold after done.
  task automatic do_op(input int w, input int av, input int bv);
    int    k, lat, lowcnt, ed, eb, eo;
    string t;
    t = $sformatf("w%0d a=%0h b=%0h", w, av, bv);
    model(w, av, bv, ed, eb, eo);
    k = 0;
    while (!get_rdy(w) && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({t, " ready"}, 32'(get_rdy(w)), 32'd1);
    drive(w, 1'b1, av, bv);
    @(negedge clk);               // after accept edge E0
    drive(w, 1'b0, av, bv);
    lat    = 0;
    lowcnt = 0;
    while (!get_done(w) && lat < 40) begin
      if (!get_rdy(w)) lowcnt++;
      @(negedge clk);
      lat++;
    end
    check({t, " latency"}, 32'(lat), 32'(w));
    check({t, " diff"},   get_diff(w),       32'(ed));
    check({t, " borrow"}, 32'(get_bor(w)),   32'(eb));
    check({t, " ovf"},    32'(get_ovf(w)),   32'(eo));
    while (!get_rdy(w) && lat < 60) begin
      lowcnt++;
      @(negedge clk);
      lat++;
    end
    check({t, " done_width"},   32'(get_done(w)), 32'd0);
    check({t, " ready_low"},    32'(lowcnt),      32'(w + 1));
    check({t, " diff_hold"},    get_diff(w),      32'(ed));
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int ndone, p0, p1, np;

    rst_n = 1'b0;
    drive(8, 1'b0, 0, 0);
    drive(3, 1'b0, 0, 0);
    drive(1, 1'b0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst in_ready", 32'(rdy8),  32'd1);
    check("rst done",     32'(done8), 32'd0);
    check("rst diff",     32'(diff8), 32'd0);
    check("rst borrow",   32'(bor8),  32'd0);
    check("rst ovf",      32'(ovf8),  32'd0);

    // Directed WIDTH=8 cases
    do_op(8, 'h05, 'h03);
    do_op(8, 'h03, 'h05);
    do_op(8, 'h80, 'h01);
    do_op(8, 'h7F, 'hFF);

    // Start while busy: extra requests at E3 and E9 must be ignored
    drive(8, 1'b1, 'h10, 'h01);
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);             // after E_c
      if (c == 2 || c == 8) drive(8, 1'b1, 'hAA, 'h55);
      else                  drive(8, 1'b0, 'hAA, 'h55);
      if (done8) ndone++;
    end
    check("busy done_count", 32'(ndone), 32'd1);
    check("busy diff",       32'(diff8), 32'h0F);
    check("busy borrow",     32'(bor8),  32'd0);
    check("busy in_ready",   32'(rdy8),  32'd1);

    // Back-to-back with start held high, output hold between pulses
    drive(8, 1'b1, 'h00, 'h00);
    np = 0; p0 = -1; p1 = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);             // after E_c
      if (c == 0)  drive(8, 1'b1, 'hFF, 'h01);
      if (c == 10) drive(8, 1'b0, 'hFF, 'h01);
      if (done8) begin
        if (np == 0) p0 = c;
        else         p1 = c;
        np++;
      end
      if (c >= 8 && c < 18) check($sformatf("b2b hold0 c%0d", c), 32'(diff8), 32'h00);
      if (c >= 18)          check($sformatf("b2b hold1 c%0d", c), 32'(diff8), 32'hFE);
      if (c >= 8) begin
        check($sformatf("b2b borrow c%0d", c), 32'(bor8), 32'd0);
        check($sformatf("b2b ovf c%0d", c),    32'(ovf8), 32'd0);
      end
    end
    check("b2b pulses",  32'(np), 32'd2);
    check("b2b first",   32'(p0), 32'd8);
    check("b2b spacing", 32'(p1 - p0), 32'd10);

    // Reset in the middle of an operation
    drive(8, 1'b1, 'h33, 'h11);
    @(negedge clk);
    drive(8, 1'b0, 'h33, 'h11);
    repeat (4) @(negedge clk);    // after E4: bit 4 is next
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst diff",     32'(diff8), 32'd0);
    check("midrst borrow",   32'(bor8),  32'd0);
    check("midrst ovf",      32'(ovf8),  32'd0);
    check("midrst done",     32'(done8), 32'd0);
    check("midrst in_ready", 32'(rdy8),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8, 'h09, 'h04);

    // Exhaustive sweeps at WIDTH=1 and WIDTH=3
    for (int x = 0; x < 2; x++)
      for (int y = 0; y < 2; y++)
        do_op(1, x, y);
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        do_op(3, x, y);

    // Random WIDTH=8 operands
    for (int i = 0; i < 20; i++)
      do_op(8, int'($urandom_range(255)), int'($urandom_range(255)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
